gpu_cr_writer: RTL

GPU_CR_WRITER -- requirements
Module: gpu_cr_writer

---
 rtl/gpu_cr_writer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/gpu_cr_writer.sv
// GPU control-register writer: 4-deep in-order host FIFO with optional frame-synchronised issue.
// Define GPU_CR_SHADOW_EN to add shadow copies of the four controller registers.
package gpu_cr_writer_pkg;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 5;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned LVL_W  = 3;

    typedef struct packed {
        logic              sync;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cr_entry_t;
endpackage

module gpu_cr_writer
    import gpu_cr_writer_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_host_valid,
    output logic              o_host_ready,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_data,
    input  logic              i_host_sync,
    input  logic              i_frame_done,
    input  logic              i_err_clr,
    output logic              o_cr_we,
    output logic [ADDR_W-1:0] o_cr_addr,
    output logic [DATA_W-1:0] o_cr_value,
    output logic [LVL_W-1:0]  o_fifo_level,
    output logic              o_busy,
    output logic              o_err_addr
`ifdef GPU_CR_SHADOW_EN
    ,
    output logic              o_shadow_output_ena,
    output logic              o_shadow_render_ena,
    output logic              o_shadow_mode,
    output logic [DATA_W-1:0] o_shadow_spirit_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_FRAME} state_t;

    state_t            state_q, state_d;
    cr_entry_t         fifo_q [DEPTH];
    cr_entry_t         fifo_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              cr_we_q, cr_we_d;
    logic [ADDR_W-1:0] cr_addr_q, cr_addr_d;
    logic [DATA_W-1:0] cr_value_q, cr_value_d;
    logic              busy_q, busy_d;
    logic              err_addr_q, err_addr_d;
    logic              accept, addr_ok, push, pop;
    cr_entry_t         head, head_d, push_entry;
`ifdef GPU_CR_SHADOW_EN
    logic              sh_out_q, sh_out_d, sh_rnd_q, sh_rnd_d, sh_mode_q, sh_mode_d;
    logic [DATA_W-1:0] sh_cnt_q, sh_cnt_d;
`endif

    assign o_host_ready = (level_q < LVL_W'(DEPTH));

    // Next-state: FIFO bookkeeping, issue decision and the state of the new head.
    always_comb begin
        fifo_d     = fifo_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cr_we_d    = 1'b0;
        cr_addr_d  = cr_addr_q;
        cr_value_d = cr_value_q;
        err_addr_d = err_addr_q;
        pop        = 1'b0;
        head       = fifo_q[rd_ptr_q];
        accept     = i_host_valid && o_host_ready;
        addr_ok    = (i_host_addr[1:0] == 2'b00);
        push       = accept && addr_ok;
        push_entry = '{sync: i_host_sync, addr: i_host_addr, data: i_host_data};
`ifdef GPU_CR_SHADOW_EN
        sh_out_d   = sh_out_q;
        sh_rnd_d   = sh_rnd_q;
        sh_mode_d  = sh_mode_q;
        sh_cnt_d   = sh_cnt_q;
`endif

        case (state_q)
            S_ISSUE:      pop = 1'b1;
            S_WAIT_FRAME: pop = i_frame_done;
            default:      pop = 1'b0;
        endcase

        if (pop) begin
            cr_we_d    = 1'b1;
            cr_addr_d  = head.addr;
            cr_value_d = head.data;
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
`ifdef GPU_CR_SHADOW_EN
            case (head.addr)
                4'h0:    sh_out_d  = head.data[0];
                4'h4:    sh_rnd_d  = head.data[0];
                4'h8:    sh_mode_d = head.data[0];
                4'hC:    sh_cnt_d  = head.data;
                default: sh_cnt_d  = sh_cnt_q;
            endcase
`endif
        end

        if (push) begin
            fifo_d[wr_ptr_q] = push_entry;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        level_d = level_q + LVL_W'(push) - LVL_W'(pop);

        // Set beats clear when both happen together.
        if (i_err_clr)
            err_addr_d = 1'b0;
        if (accept && !addr_ok)
            err_addr_d = 1'b1;

        head_d = fifo_d[rd_ptr_d];
        if (level_d == '0)
            state_d = S_IDLE;
        else if (head_d.sync)
            state_d = S_WAIT_FRAME;
        else
            state_d = S_ISSUE;

        busy_d = (level_d != '0) || pop;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            for (int i = 0; i < int'(DEPTH); i++)
                fifo_q[i] <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            cr_we_q    <= 1'b0;
            cr_addr_q  <= '0;
            cr_value_q <= '0;
            busy_q     <= 1'b0;
            err_addr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fifo_q     <= fifo_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            cr_we_q    <= cr_we_d;
            cr_addr_q  <= cr_addr_d;
            cr_value_q <= cr_value_d;
            busy_q     <= busy_d;
            err_addr_q <= err_addr_d;
        end
    end

`ifdef GPU_CR_SHADOW_EN
    // Shadow reset values mirror the controller's own register reset state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_out_q  <= 1'b1;
            sh_rnd_q  <= 1'b1;
            sh_mode_q <= 1'b1;
            sh_cnt_q  <= DATA_W'(2);
        end else begin
            sh_out_q  <= sh_out_d;
            sh_rnd_q  <= sh_rnd_d;
            sh_mode_q <= sh_mode_d;
            sh_cnt_q  <= sh_cnt_d;
        end
    end

    assign o_shadow_output_ena = sh_out_q;
    assign o_shadow_render_ena = sh_rnd_q;
    assign o_shadow_mode       = sh_mode_q;
    assign o_shadow_spirit_cnt = sh_cnt_q;
`endif

    assign o_cr_we      = cr_we_q;
    assign o_cr_addr    = cr_addr_q;
    assign o_cr_value   = cr_value_q;
    assign o_fifo_level = level_q;
    assign o_busy       = busy_q;
    assign o_err_addr   = err_addr_q;

endmodule
